rv32imf_fp_normalize: RTL
=========================

RV32IMF_FP_NORMALIZE -- requirements
Module: rv32imf_fp_normalize

Interface
REQ-001 Parameter MANT_W, default 48, is the unnormalized mantissa width (product or sum datapath).
REQ-002 Parameter EXP_W, default 10, is the signed biased-exponent width.
REQ-003 clk_i  input  1  is the single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  is the asynchronous, active-high reset.
REQ-005 flush_i  input  1  discards all in-flight operations.
REQ-006 in_valid_i / in_ready_o  input / output  1 / 1  form the upstream valid/ready handshake.
REQ-007 in_sign_i / in_exp_i / in_mant_i / in_sticky_i  input  1 / EXP_W signed / MANT_W / 1  carry the operand.
REQ-008 out_valid_o / out_ready_i  output / input  1 / 1  form the downstream valid/ready handshake.
REQ-009 out_sign_o / out_exp_o / out_mant_o / out_sticky_o / out_zero_o  output  1 / EXP_W signed / MANT_W / 1 / 1  carry the normalized result.

Function
REQ-010 A transfer SHALL occur on a rising edge where valid and ready are both high; an unaccepted output SHALL hold all payload stable.
REQ-011 The pipeline SHALL have two register stages: S1 captures the operand plus its leading-zero count (lzc); S2 captures the shifted result.
REQ-012 With out_ready_i held high, latency SHALL be 2 cycles from acceptance to out_valid_o, at throughput 1 per cycle.
REQ-013 Enables: s2_en = ~s2_valid | out_ready_i; s1_en = ~s1_valid | s2_en; in_ready_o = s1_en. The combinational path from out_ready_i to in_ready_o is permitted.
REQ-014 lzc SHALL be MANT_W-1 minus the index of the most significant set bit of in_mant_i, computed on the bit-reversed mantissa.
REQ-015 If in_exp_i - lzc >= 1: shift = lzc and out_exp = in_exp_i - lzc.
REQ-016 Else if in_exp_i >= 1: shift = in_exp_i - 1 and out_exp = 0 (denormal).
REQ-017 Else: shift = 0 and out_exp = 0.
REQ-018 out_mant_o SHALL be in_mant_i shifted left by shift, zero-filled; sign and sticky SHALL pass through unchanged.
REQ-019 If in_mant_i == 0, out_zero_o = 1, out_exp_o = 0 and out_mant_o = 0; otherwise out_zero_o = 0.
REQ-020 Exponent arithmetic SHALL be performed at EXP_W+1 bits signed so that no intermediate wrap-around occurs.
REQ-021 Flush SHALL clear s1_valid and s2_valid on the next edge; an input accepted in the flush cycle SHALL be dropped. in_ready_o is unaffected by flush_i.
REQ-022 A simultaneous accept and emit at each stage SHALL neither lose nor duplicate an operation, and order SHALL be preserved.

Reset
REQ-023 On rst_i, all valid bits and payload registers SHALL clear asynchronously.
REQ-024 While rst_i is high, every output SHALL be 0 except in_ready_o, which SHALL be 1.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight data without emitting a partial result.

Structure
REQ-026 Default MANT_W/EXP_W constants and a struct fp_norm_t {sign, exp, mant, sticky} SHALL reside in rv32imf_pkg.
REQ-027 The leading-one search SHALL instantiate the existing rv32imf_ff_one (LEN = MANT_W) as the single sub-module; its no-ones flag drives zero detection.
REQ-028 The shifter SHALL be a single-level barrel shift inside S2 input logic; no further sub-modules.

Verification (MANT_W=48, EXP_W=10)
REQ-029 mant=48'h0000_0000_0001, exp=100 -> 2 cycles later: mant=48'h8000_0000_0000, exp=53, zero=0.
REQ-030 mant=0, exp=77, sticky=1 -> zero=1, exp=0, mant=0, sticky=1.
REQ-031 mant=48'h0000_0100_0000, exp=10 -> denormal clamp: shift 9, mant=48'h0002_0000_0000, exp=0.
REQ-032 out_ready_i low 5 cycles, 3 back-to-back inputs -> 2 accepted, in_ready_o low, third held; release -> 3 results in order, one per cycle.
REQ-033 Both stages full, flush_i pulsed -> out_valid_o=0 next cycle; a new input then emerges exactly 2 cycles after its acceptance.
REQ-034 rst_i asserted between edges with both stages full -> out_valid_o=0 and payload=0 without waiting for a clock edge.

Source files
------------

// File: rtl/rv32imf_pkg.sv
// Shared constants and payload type for the rv32imf floating-point datapath.
package rv32imf_pkg;

    localparam int unsigned MANT_W_DEF = 48;
    localparam int unsigned EXP_W_DEF  = 10;

    typedef struct packed {
        logic                        sign;
        logic signed [EXP_W_DEF-1:0] exp;
        logic [MANT_W_DEF-1:0]       mant;
        logic                        sticky;
    } fp_norm_t;

endpackage

// File: rtl/rv32imf_ff_one.sv
// Find-first-one: index of the least significant set bit, plus an all-zero flag.
module rv32imf_ff_one #(
    parameter  int unsigned LEN   = 48,
    localparam int unsigned IDX_W = (LEN > 1) ? $clog2(LEN) : 1
) (
    input  logic [LEN-1:0]   i_vec,
    output logic [IDX_W-1:0] o_index,
    output logic             o_no_ones
);

    // Scanning downward lets the lowest set bit win.
    always_comb begin
        o_index = '0;
        for (int i = int'(LEN) - 1; i >= 0; i--) begin
            if (i_vec[i]) o_index = IDX_W'(i);
        end
    end

    assign o_no_ones = ~|i_vec;

endmodule

// File: rtl/rv32imf_fp_normalize.sv
// Two-stage normalizer: S1 registers the operand and its leading-zero count,
// S2 registers the left-shifted mantissa with denormal clamping of the exponent.
module rv32imf_fp_normalize
    import rv32imf_pkg::*;
#(
    parameter int unsigned MANT_W = MANT_W_DEF,
    parameter int unsigned EXP_W  = EXP_W_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic                    in_sign_i,
    input  logic signed [EXP_W-1:0] in_exp_i,
    input  logic [MANT_W-1:0]       in_mant_i,
    input  logic                    in_sticky_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic                    out_sign_o,
    output logic signed [EXP_W-1:0] out_exp_o,
    output logic [MANT_W-1:0]       out_mant_o,
    output logic                    out_sticky_o,
    output logic                    out_zero_o
);

    localparam int unsigned LZC_W = (MANT_W > 1) ? $clog2(MANT_W) : 1;

    logic                    r_s1_valid;
    logic                    r_s1_sign;
    logic signed [EXP_W-1:0] r_s1_exp;
    logic [MANT_W-1:0]       r_s1_mant;
    logic                    r_s1_sticky;
    logic [LZC_W-1:0]        r_s1_lzc;
    logic                    r_s1_zero;

    logic                    r_s2_valid;
    logic                    r_s2_sign;
    logic signed [EXP_W-1:0] r_s2_exp;
    logic [MANT_W-1:0]       r_s2_mant;
    logic                    r_s2_sticky;
    logic                    r_s2_zero;

    logic                    w_s1_en;
    logic                    w_s2_en;
    logic [MANT_W-1:0]       w_mant_rev;
    logic [LZC_W-1:0]        w_lzc;
    logic                    w_no_ones;
    logic signed [EXP_W:0]   w_exp_ext;
    logic signed [EXP_W:0]   w_lzc_ext;
    logic signed [EXP_W:0]   w_diff;
    logic signed [EXP_W:0]   w_exp_m1;
    logic [LZC_W-1:0]        w_shift;
    logic signed [EXP_W-1:0] w_exp_nxt;

    assign w_s2_en    = ~r_s2_valid | out_ready_i;
    assign w_s1_en    = ~r_s1_valid | w_s2_en;
    assign in_ready_o = w_s1_en;

    // Lowest set bit of the reversed mantissa is the leading-zero count.
    always_comb begin
        w_mant_rev = '0;
        for (int i = 0; i < int'(MANT_W); i++) begin
            w_mant_rev[i] = in_mant_i[int'(MANT_W) - 1 - i];
        end
    end

    rv32imf_ff_one #(
        .LEN (MANT_W)
    ) u_ff_one (
        .i_vec     (w_mant_rev),
        .o_index   (w_lzc),
        .o_no_ones (w_no_ones)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1_valid  <= 1'b0;
            r_s1_sign   <= 1'b0;
            r_s1_exp    <= '0;
            r_s1_mant   <= '0;
            r_s1_sticky <= 1'b0;
            r_s1_lzc    <= '0;
            r_s1_zero   <= 1'b0;
        end else begin
            if (flush_i) begin
                r_s1_valid <= 1'b0;
            end else if (w_s1_en) begin
                r_s1_valid <= in_valid_i;
            end
            if (w_s1_en && in_valid_i) begin
                r_s1_sign   <= in_sign_i;
                r_s1_exp    <= in_exp_i;
                r_s1_mant   <= in_mant_i;
                r_s1_sticky <= in_sticky_i;
                r_s1_lzc    <= w_lzc;
                r_s1_zero   <= w_no_ones;
            end
        end
    end

    // One extra exponent bit keeps exp - lzc and exp - 1 from wrapping.
    assign w_exp_ext = {r_s1_exp[EXP_W-1], r_s1_exp};
    assign w_lzc_ext = {{(EXP_W + 1 - LZC_W){1'b0}}, r_s1_lzc};
    assign w_diff    = w_exp_ext - w_lzc_ext;
    assign w_exp_m1  = w_exp_ext - (EXP_W + 1)'(1);

    // Full normalization when the exponent allows it, otherwise clamp to denormal.
    always_comb begin
        w_shift   = '0;
        w_exp_nxt = '0;
        if (r_s1_zero) begin
            w_shift   = '0;
            w_exp_nxt = '0;
        end else if (!w_diff[EXP_W] && (|w_diff)) begin
            w_shift   = r_s1_lzc;
            w_exp_nxt = EXP_W'(w_diff);
        end else if (!r_s1_exp[EXP_W-1] && (|r_s1_exp)) begin
            w_shift   = LZC_W'(w_exp_m1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s2_valid  <= 1'b0;
            r_s2_sign   <= 1'b0;
            r_s2_exp    <= '0;
            r_s2_mant   <= '0;
            r_s2_sticky <= 1'b0;
            r_s2_zero   <= 1'b0;
        end else begin
            if (flush_i) begin
                r_s2_valid <= 1'b0;
            end else if (w_s2_en) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s2_en && r_s1_valid) begin
                r_s2_sign   <= r_s1_sign;
                r_s2_exp    <= w_exp_nxt;
                r_s2_mant   <= r_s1_mant << w_shift;
                r_s2_sticky <= r_s1_sticky;
                r_s2_zero   <= r_s1_zero;
            end
        end
    end

    assign out_valid_o  = r_s2_valid;
    assign out_sign_o   = r_s2_sign;
    assign out_exp_o    = r_s2_exp;
    assign out_mant_o   = r_s2_mant;
    assign out_sticky_o = r_s2_sticky;
    assign out_zero_o   = r_s2_zero;

endmodule
